// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame-level debounce,
// reporting one accepted key code with a single-cycle valid strobe.
module keypad_scanner #(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o
);
  localparam int TW = SCAN_TICKS > 1 ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(SCAN_TICKS - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;
  state_t        state_q;
  logic [3:0]    col_m_q, col_s_q, row_q, cand_q, cnt_q, key_code_q;
  logic [1:0]    row_sel_q;
  logic [TW-1:0] tick_q;
  logic [11:0]   frame_q;
  logic          key_valid_q, key_held_q;
  logic          sample, frame_end, single, match;
  logic [15:0]   hits;
  logic [4:0]    n_hits;
  logic [3:0]    key;
  assign row_o       = row_q;
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;
  // Rows 0..2 live in frame_q; row 3 is classified straight from col_s on its sample cycle.
  always_comb begin
    sample    = tick_q == TICK_MAX;
    frame_end = sample && row_sel_q == 2'd3;
    hits      = {~col_s_q, frame_q};
    n_hits    = '0;
    key       = '0;
    for (int i = 0; i < 16; i++) begin
      if (hits[i]) begin
        n_hits = n_hits + 5'd1;
        key    = 4'(i);
      end
    end
    single = n_hits == 5'd1;
    match  = single && key == key_code_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_m_q   <= 4'b1111;
      col_s_q   <= 4'b1111;
      tick_q    <= '0;
      row_sel_q <= '0;
      row_q     <= 4'b1110;
      frame_q   <= '0;
    end else begin
      col_m_q <= col_i;
      col_s_q <= col_m_q;
      tick_q  <= sample ? '0 : tick_q + 1'b1;
      if (sample) begin
        row_sel_q <= row_sel_q + 2'd1;
        row_q     <= {row_q[2:0], row_q[3]};
        frame_q   <= {~col_s_q, frame_q[11:4]};
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (frame_end) begin
        case (state_q)
          IDLE: if (single) begin
            cand_q <= key;
            cnt_q  <= 4'd1;
            if (DEBOUNCE_SCANS == 1) begin
              key_code_q  <= key;
              key_held_q  <= 1'b1;
              key_valid_q <= 1'b1;
              state_q     <= HELD;
            end else state_q <= PRESS_WAIT;
          end
          PRESS_WAIT: if (!single) state_q <= IDLE;
          else if (key != cand_q) begin
            cand_q <= key;
            cnt_q  <= 4'd1;
          end else if (cnt_q + 4'd1 == DEB) begin
            key_code_q  <= cand_q;
            key_held_q  <= 1'b1;
            key_valid_q <= 1'b1;
            state_q     <= HELD;
          end else cnt_q <= cnt_q + 4'd1;
          HELD: if (!match) begin
            cnt_q <= 4'd1;
            if (DEBOUNCE_SCANS == 1) begin
              key_held_q <= 1'b0;
              state_q    <= IDLE;
            end else state_q <= REL_WAIT;
          end
          REL_WAIT: if (match) state_q <= HELD;
          else if (cnt_q + 4'd1 == DEB) begin
            key_held_q <= 1'b0;
            state_q    <= IDLE;
          end else cnt_q <= cnt_q + 4'd1;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving rows active-low one at a time and reading the four column lines.
- Columns are active-low with pull-ups.
- Per-frame results are debounced, and one stable key code is reported with a single-cycle valid strobe.
- This is the input-side counterpart to the multiplexed seven-segment driver. It sits beside the top-level game FSM and supplies direction and control keys.

Parameters:
- SCAN_TICKS, 100000: clock cycles each row is driven (1 ms at 100 MHz).
- DEBOUNCE_SCANS, 4: consecutive identical full-scan frames needed to accept a press or a release. Legal range 1..15.

Ports:
- clock  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- col  input  4  keypad column lines, active-low, asynchronous to clock.
- row  output  4  keypad row drive, active-low, exactly one bit low at any time.
- key_code  output  4  last accepted key, encoded {row_index[1:0], col_index[1:0]}.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while the accepted key is debounced-pressed.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - row=4'b1110 and row_sel=0.
  - Tick counter = 0, state = IDLE, debounce count = 0.
  - key_code = 0, key_valid = 0, key_held = 0.
  - Column synchronizer = 4'b1111. Frame accumulators are cleared.
- Column synchronizer: two flip-flops on col. The internal signal is col_s.
- Row timing:
  - Tick counter runs 0..SCAN_TICKS-1.
  - When the counter equals SCAN_TICKS-1, col_s is sampled for the current row_sel, then row_sel advances (wrapping 3→0) and the counter clears.
  - row = ~(4'b0001 << row_sel).
- Frame classification, evaluated on the sample cycle for row_sel=3, using all four row samples:
  - NONE: no column low in any row.
  - SINGLE(k): exactly one low bit across the frame. k = {row, col index}, with col[0] giving index 0.
  - MULTI: two or more low bits. MULTI is treated exactly as NONE; there is no ghost-key resolution.
- Debounce FSM. It advances only on frame-end cycles.
  - IDLE:
    - SINGLE(k): cand=k, cnt=1. If DEBOUNCE_SCANS==1, accept immediately; otherwise go to PRESS_WAIT.
    - NONE or MULTI: stay in IDLE.
  - PRESS_WAIT:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS, accept.
    - SINGLE(j) with j≠cand: cand=j, cnt=1, stay.
    - NONE or MULTI: go to IDLE.
  - Accept:
    - key_code=cand, key_held=1, key_valid=1 for exactly the next clock cycle.
    - Go to HELD.
  - HELD:
    - SINGLE(key_code): stay.
    - Anything else: cnt=1, go to REL_WAIT. If DEBOUNCE_SCANS==1, release immediately.
  - REL_WAIT:
    - SINGLE(key_code): go back to HELD, with no new key_valid.
    - Anything else: cnt+1. When cnt reaches DEBOUNCE_SCANS, key_held=0 and go to IDLE.
  - Output retention: key_code holds its value after release until the next accept.
- Latency: a key stable from a frame start gives key_valid after DEBOUNCE_SCANS frames, where one frame = 4*SCAN_TICKS cycles. Allow up to one extra frame for misaligned onset plus 2 synchronizer cycles.
- Auto-repeat: none. Holding a key produces exactly one key_valid.
- A new key pressed while another is held:
  - The FSM first passes through REL_WAIT, because the frame is MULTI or a different SINGLE.
  - It must complete release before the new key can be accepted from IDLE.
- Reset mid-operation: the asynchronous clear aborts any partial debounce. Scanning restarts at row 0 and no key_valid is emitted.
- Widths:
  - Tick counter wide enough for SCAN_TICKS-1 (17 bits at the default).
  - Debounce count is 4 bits.

Test Plan:
Bench setup for all scenarios: SCAN_TICKS=4, DEBOUNCE_SCANS=2 (one frame = 16 cycles). Keypad model: col[c]=0 whenever row[r]=0 and key (r,c) is pressed.
- Reset: hold reset=0, then release → row=4'b1110, key_code=0, key_valid=0, key_held=0. row then cycles 1110→1101→1011→0111 every 4 cycles.
- Single press: press (2,1) and keep it stable → within 3 frames plus 2 cycles, key_code=4'b1001, key_held=1, and exactly one key_valid pulse of 1 cycle. No further pulses over 10 more frames.
- Bounce: press (0,3) for one frame only, then release → key_valid is never asserted and key_held stays 0.
- Multi-key: press (0,0) and (1,3) together for 5 frames → no key_valid and key_code unchanged.
- Release: from the held (2,1) state, release → key_held=0 after 2 full non-matching frames. key_code remains 9. A one-frame release glitch must keep key_held=1 with no new pulse.
- Reset mid-press: assert reset during PRESS_WAIT for (3,2) → all outputs 0 immediately. After reset is released with the key still held, a fresh accept yields key_code=4'b1110 with one pulse.
